// File: rtl/tsbus_reader_if.sv
// Handshake and status bundle between a tristate-bus writer/consumer and the
// tsbus_reader capture block. The shared tristate lines themselves stay a
// plain inout port on the reader so the net is resolved outside the bundle.
interface tsbus_reader_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] drive;      // per-line drive enables from the writer
    logic [WIDTH-1:0] out_data;   // FIFO head
    logic             out_valid;  // FIFO non-empty
    logic             out_ready;  // consumer accepts the head
    logic [LW-1:0]    level;      // FIFO occupancy
    logic             overflow;   // sticky dropped-capture flag
    logic             partial;    // previous edge saw a partially driven bus

    // Writer/consumer side.
    modport master (
        output drive,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  level,
        input  overflow,
        input  partial
    );

    // Capture block side.
    modport slave (
        input  drive,
        input  out_ready,
        output out_data,
        output out_valid,
        output level,
        output overflow,
        output partial
    );
endinterface

// File: rtl/tsbus_reader.sv
// Passive tristate-bus reader. Watches a shared bus, waits until every line
// is driven and the value has held for STABLE consecutive edges, then pushes
// that value once into a small capture FIFO drained by a ready/valid consumer.
module tsbus_reader #(
    parameter int WIDTH  = 2,
    parameter int DEPTH  = 4,
    parameter int STABLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] ts,
    tsbus_reader_if.slave    bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(STABLE + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // The reader only listens; it never drives the shared lines.
    assign ts = {WIDTH{1'bz}};

    logic [WIDTH-1:0] ts_sample;
    logic             full_drive;

    assign ts_sample  = ts;
    assign full_drive = &bus.drive;

    // ------------------------------------------------------------------
    // Stability tracker
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] stored_q, stored_d;
    logic             push;

    // Next-state logic: track how long the fully driven value has held and
    // request exactly one capture per stable value.
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        stored_d = stored_q;
        push     = 1'b0;

        if (!full_drive) begin
            // Any edge with a line released abandons the current value.
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    stored_d = ts_sample;
                    count_d  = CW'(1);
                    if (STABLE == 1) begin
                        push    = 1'b1;
                        state_d = HELD;
                    end else begin
                        state_d = SETTLE;
                    end
                end

                SETTLE: begin
                    if (ts_sample == stored_q) begin
                        // Saturate so the count can never wrap back past STABLE.
                        count_d = (count_q == CW'(STABLE)) ? count_q : count_q + CW'(1);
                        if (count_d == CW'(STABLE)) begin
                            push    = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        stored_d = ts_sample;
                        count_d  = CW'(1);
                        if (STABLE == 1) begin
                            push    = 1'b1;
                            state_d = HELD;
                        end
                    end
                end

                HELD: begin
                    // Same value keeps holding: already captured, do nothing.
                    if (ts_sample != stored_q) begin
                        stored_d = ts_sample;
                        count_d  = CW'(1);
                        if (STABLE == 1) begin
                            push = 1'b1;
                        end else begin
                            state_d = SETTLE;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Tracker state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            stored_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            stored_q <= stored_d;
        end
    end

    // Partial-drive flag: some lines driven, but not all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.partial <= 1'b0;
        end else begin
            bus.partial <= (bus.drive != '0) && !full_drive;
        end
    end

    // ------------------------------------------------------------------
    // Capture FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level_q;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;

    assign fifo_full = (level_q == LW'(DEPTH));
    assign pop       = bus.out_ready && (level_q != '0);
    // A pop on the same edge frees the slot, so a push into a full FIFO is
    // only dropped when nothing leaves.
    assign push_ok   = push && (!fifo_full || pop);

    // Storage array write.
    // NOTE: the data array has no reset; occupancy and pointers alone decide
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= stored_d;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (push && !push_ok) begin
                bus.overflow <= 1'b1;
            end
        end
    end

    assign bus.level     = level_q;
    assign bus.out_valid = (level_q != '0);
    assign bus.out_data  = mem[rd_ptr];

endmodule
